// File: rtl/ovl_chk_pkg.sv
// Shared definitions for the OVL-style assertion checkers.
package ovl_chk_pkg;

  // Window tracking state: closed (IDLE) or open (WIN).
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WIN  = 1'b1
  } ovl_state_e;

  // Bit positions inside the registered fire vector.
  localparam int FIRE_VIOL = 0;
  localparam int FIRE_XCHK = 1;
  localparam int FIRE_COV  = 2;
  localparam int FIRE_W    = 3;

endpackage

// File: rtl/ovl_win_unchange_chk.sv
// Window-unchange checker: once start_event opens a window, test_expr must
// hold the value captured on the start edge on every edge up to and
// including the edge that samples end_event. Passive monitor; results are
// reported as single-cycle pulses on the registered fire vector.
//
// Event handshake: there is no valid/ready pairing here. start_event and
// end_event are level-sampled on each rising clock edge; a 1 on a sampled
// edge is the event, anything else (0, X or Z) is no event.
module ovl_win_unchange_chk
  import ovl_chk_pkg::*;
#(
  parameter int width       = 1,
  parameter bit coverage_en = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              start_event,
  input  logic [width-1:0]  test_expr,
  input  logic              end_event,
  output logic [FIRE_W-1:0] fire,
  output ovl_state_e        state_dbg
);

  ovl_state_e        state_q;
  ovl_state_e        state_d;
  logic [width-1:0]  ref_val_q;
  logic [width-1:0]  ref_val_d;
  logic [FIRE_W-1:0] fire_d;

  logic start_s;
  logic end_s;
  logic xchk;
  logic viol;
  logic cov;

  // X/Z events count as "no event" for state transitions. The case
  // equality collapses to a plain wire in synthesis.
  assign start_s = (start_event === 1'b1);
  assign end_s   = (end_event === 1'b1);

  // Unknown-event detection is only meaningful in simulation; in synthesis
  // the comparison against X folds to 0.
  assign xchk = ((start_event ^ end_event) === 1'bx);

  // Next-state, reference capture and unmasked fire terms.
  always_comb begin
    state_d   = state_q;
    ref_val_d = ref_val_q;
    viol      = 1'b0;
    cov       = 1'b0;
    unique case (state_q)
      IDLE: begin
        // end_event has no meaning while the window is closed.
        if (start_s) begin
          ref_val_d = test_expr;
          state_d   = WIN;
          cov       = coverage_en;
        end
      end
      WIN: begin
        // Compare on every open edge, including the closing one. A
        // mismatch containing X/Z bits is not reported.
        viol = ((test_expr != ref_val_q) === 1'b1);
        if (end_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Every fire bit is masked by enable before it is registered.
  always_comb begin
    fire_d            = '0;
    fire_d[FIRE_VIOL] = viol;
    fire_d[FIRE_XCHK] = xchk;
    fire_d[FIRE_COV]  = cov;
    fire_d            = fire_d & {FIRE_W{enable}};
  end

  // State, reference value and fire register; reset discards any open window.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ref_val_q <= '0;
      fire      <= '0;
    end else begin
      state_q   <= state_d;
      ref_val_q <= ref_val_d;
      fire      <= fire_d;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_ovl_win_unchange_chk.sv
// Bench for ovl_win_unchange_chk: directed scenarios with literal
// expectations, followed by randomized traffic, all checked each cycle
// against a window model.
module tb_ovl_win_unchange_chk;
  import ovl_chk_pkg::*;

  localparam int W = 4;

  logic           clock;
  logic           reset;
  logic           enable;
  logic           start_event;
  logic           end_event;
  logic [W-1:0]   test_expr;
  logic [2:0]     fire;
  ovl_state_e     state_dbg;

  int checks   = 0;
  int failures = 0;

  logic [2:0] exp_q[$];

  // model state
  bit         m_open = 1'b0;
  logic [W-1:0] m_ref = '0;

  ovl_win_unchange_chk #(
    .width      (W),
    .coverage_en(1'b1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .start_event(start_event),
    .test_expr  (test_expr),
    .end_event  (end_event),
    .fire       (fire),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- model ----------------
  // At each rising edge decide, from the window rules, what fire must show
  // during the following cycle.
  always @(posedge clock) begin
    logic [2:0] f;
    f = 3'b000;
    if (reset) begin
      m_open = 1'b0;
      m_ref  = '0;
    end else begin
      if (!m_open) begin
        if (start_event) begin
          m_ref  = test_expr;
          m_open = 1'b1;
          f[2]   = 1'b1;
        end
      end else begin
        if (test_expr != m_ref) f[0] = 1'b1;
        if (end_event) m_open = 1'b0;
      end
      if (!enable) f = 3'b000;
    end
    exp_q.push_back(f);
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clock) begin
    logic [2:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (fire !== e) begin
        failures++;
        $display("FAIL model_fire t=%0t got=%b exp=%b", $time, fire, e);
      end
    end
  end

  // ---------------- driver / literal checks ----------------
  task automatic drive(input logic s, input logic e, input logic [W-1:0] t,
                       input logic en = 1'b1);
    @(negedge clock);
    #1;
    start_event = s;
    end_event   = e;
    test_expr   = t;
    enable      = en;
  endtask

  // Literal expectation on fire; called right after a drive, so it sees the
  // outcome of the step driven before it.
  task automatic check_fire(input string name, input logic [2:0] exp);
    checks++;
    if (fire !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, fire, exp);
    end
  endtask

  task automatic check_state(input string name, input ovl_state_e exp);
    checks++;
    if (state_dbg !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, state_dbg, exp);
    end
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b1;
    start_event = 1'b0;
    end_event   = 1'b0;
    test_expr   = '0;

    // 1) reset held: window activity must not fire anything
    drive(1'b1, 1'b0, 4'b0101);
    drive(1'b0, 1'b0, 4'b0100);
    check_fire("rst_hold_a", 3'b000);
    drive(1'b0, 1'b1, 4'b0100);
    check_fire("rst_hold_b", 3'b000);
    drive(1'b0, 1'b0, 4'b0100);
    check_fire("rst_hold_c", 3'b000);
    check_state("rst_state", IDLE);

    // 2) stable window: coverage pulse only
    @(negedge clock); #1 reset = 1'b0;
    drive(1'b1, 1'b0, 4'b0101);
    drive(1'b0, 1'b0, 4'b0101);
    check_fire("open_cov", 3'b100);
    check_state("open_state", WIN);
    repeat (3) drive(1'b0, 1'b0, 4'b0101);
    check_fire("stable_hold", 3'b000);
    drive(1'b0, 1'b1, 4'b0101);
    drive(1'b0, 1'b0, 4'b0000);
    check_fire("stable_end", 3'b000);
    drive(1'b0, 1'b0, 4'b0000);
    check_fire("after_end_change", 3'b000);
    check_state("closed_state", IDLE);

    // 3) change inside window fires every mismatching edge, window stays open
    drive(1'b1, 1'b0, 4'b0011);
    drive(1'b0, 1'b0, 4'b0011);
    drive(1'b0, 1'b0, 4'b0111);
    drive(1'b0, 1'b0, 4'b0111);
    check_fire("viol_first", 3'b001);
    drive(1'b0, 1'b1, 4'b0111);
    check_fire("viol_again", 3'b001);
    check_state("viol_still_open", WIN);
    drive(1'b0, 1'b0, 4'b0000);
    check_fire("viol_end_edge", 3'b001);
    drive(1'b0, 1'b0, 4'b0000);
    check_fire("viol_after_close", 3'b000);

    // 4) change on the end edge fires, change after end does not
    drive(1'b1, 1'b0, 4'b1010);
    drive(1'b0, 1'b1, 4'b1011);
    check_fire("end_cov", 3'b100);
    drive(1'b0, 1'b0, 4'b0000);
    check_fire("end_edge_change", 3'b001);
    drive(1'b0, 1'b0, 4'b1111);
    check_fire("post_end_change", 3'b000);

    // 5) start+end together in IDLE opens; restart in WIN does not recapture
    drive(1'b1, 1'b1, 4'b0110);
    drive(1'b1, 1'b0, 4'b1001);
    check_fire("both_idle_open", 3'b100);
    drive(1'b0, 1'b0, 4'b1001);
    check_fire("no_recapture", 3'b001);
    drive(1'b0, 1'b0, 4'b0110);
    check_fire("orig_ref_mismatch", 3'b001);
    drive(1'b1, 1'b1, 4'b0110);
    check_fire("orig_ref_match", 3'b000);
    drive(1'b0, 1'b0, 4'b0000);
    check_fire("both_win_close", 3'b000);
    check_state("both_win_state", IDLE);

    // 6) enable masking, then asynchronous reset mid-window
    drive(1'b1, 1'b0, 4'b0001);
    drive(1'b0, 1'b0, 4'b0010, 1'b0);
    check_fire("en_cov", 3'b100);
    drive(1'b0, 1'b0, 4'b0010, 1'b1);
    check_fire("en_masked", 3'b000);
    drive(1'b0, 1'b0, 4'b0001);
    check_fire("en_restored", 3'b001);
    drive(1'b0, 1'b0, 4'b0001);
    check_fire("match_again", 3'b000);
    drive(1'b0, 1'b0, 4'b0010);
    drive(1'b0, 1'b0, 4'b0010);
    check_fire("pre_reset_viol", 3'b001);
    #1 reset = 1'b1;
    #1 check_fire("async_reset_clear", 3'b000);
    check_state("async_reset_state", IDLE);
    @(negedge clock); #1 reset = 1'b0;
    drive(1'b0, 1'b1, 4'b0000);
    drive(1'b0, 1'b0, 4'b0000);
    check_fire("old_window_gone", 3'b000);
    drive(1'b1, 1'b0, 4'b1100);
    drive(1'b0, 1'b0, 4'b1100);
    check_fire("recapture_cov", 3'b100);
    drive(1'b0, 1'b1, 4'b1100);
    check_fire("recapture_match", 3'b000);
    drive(1'b0, 1'b0, 4'b0000);
    check_fire("recapture_close", 3'b000);

    // 7) randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic s, e, en;
      logic [W-1:0] t;
      s  = ($urandom_range(0, 7) == 0);
      e  = ($urandom_range(0, 5) == 0);
      en = ($urandom_range(0, 9) != 0);
      t  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : test_expr;
      drive(s, e, t, en);
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
        @(negedge clock); #1 reset = 1'b0;
      end
    end

    drive(1'b0, 1'b0, test_expr);
    @(negedge clock);
    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
